// File: rtl/oc_operand_gather.sv
// oc_operand_gather: routes returning register-file bank reads into per-collector
// src1/src2 buffers, tracks collector completion and dispatches full collectors
// round-robin over a valid/ready handshake.
// Optional: define OPGATHER_PERF_CNT_EN to add the perf_returns/perf_disps counters.
module oc_operand_gather #(
  parameter int DATA_W    = 256,
  parameter int NUM_OC    = 4,
  parameter int RF_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            rf_rd_i,
  input  logic [15:0]           ocid_i,
  input  logic [3:0]            same_i,
  input  logic [4*DATA_W-1:0]   rf_data_i,
  input  logic                  alloc_valid,
  input  logic [1:0]            alloc_oc,
  input  logic [1:0]            alloc_need,
  output logic [3:0]            oc_busy,
  output logic                  disp_valid,
  input  logic                  disp_ready,
  output logic [1:0]            disp_oc,
  output logic [DATA_W-1:0]     disp_src1,
  output logic [DATA_W-1:0]     disp_src2,
  output logic                  err
`ifdef OPGATHER_PERF_CNT_EN
  ,
  output logic [15:0]           perf_returns,
  output logic [15:0]           perf_disps
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_GATHER, S_READY} state_t;

  // tag layout: [5] read issued, [4] valid, [3:2] collector, [1] slot, [0] same
  logic [5:0]        tag_pipe [4][RF_RD_LAT];
  logic [1:0]        wr_mask  [4];
  logic [1:0]        wr_oc    [4];
  logic [1:0]        claim    [NUM_OC];
  logic              ret_err;
  logic              alloc_err;

  state_t            state_q  [NUM_OC];
  state_t            state_d  [NUM_OC];
  logic [1:0]        need_q   [NUM_OC];
  logic [1:0]        need_d   [NUM_OC];
  logic [1:0]        have_q   [NUM_OC];
  logic [1:0]        have_d   [NUM_OC];
  logic [DATA_W-1:0] opnd_q   [NUM_OC][2];

  logic              hs;
  logic [1:0]        rr_ptr;
  logic [1:0]        start;
  logic [1:0]        idx;
  logic [1:0]        pick;
  logic              pick_valid;

  assign hs = disp_valid & disp_ready;

  // Delay each bank's tag so it lines up with the read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned b = 0; b < 4; b++)
        for (int unsigned s = 0; s < RF_RD_LAT; s++)
          tag_pipe[b][s] <= '0;
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        tag_pipe[b][0] <= {rf_rd_i[b], ocid_i[4*b +: 4], same_i[b]};
        for (int unsigned s = 1; s < RF_RD_LAT; s++)
          tag_pipe[b][s] <= tag_pipe[b][s-1];
      end
    end
  end

  // Decode returning tags; lower banks claim an oc/slot first, later duplicates are dropped
  always_comb begin : ret_decode
    logic [5:0] t;
    logic [1:0] mask;
    ret_err = 1'b0;
    t       = '0;
    mask    = '0;
    for (int unsigned k = 0; k < NUM_OC; k++) claim[k] = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      t          = tag_pipe[b][RF_RD_LAT-1];
      mask       = t[0] ? 2'b11 : (t[1] ? 2'b10 : 2'b01);
      wr_mask[b] = '0;
      wr_oc[b]   = t[3:2];
      if (t[5] && t[4]) begin
        if (state_q[t[3:2]] != S_GATHER) begin
          ret_err = 1'b1;
        end else if ((claim[t[3:2]] & mask) != 2'b00) begin
          ret_err = 1'b1;
        end else begin
          wr_mask[b]     = mask;
          claim[t[3:2]]  = claim[t[3:2]] | mask;
        end
      end
    end
  end

  // Operand buffers take accepted returns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_OC; k++) begin
        opnd_q[k][0] <= '0;
        opnd_q[k][1] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_mask[b][0]) opnd_q[wr_oc[b]][0] <= rf_data_i[b*DATA_W +: DATA_W];
        if (wr_mask[b][1]) opnd_q[wr_oc[b]][1] <= rf_data_i[b*DATA_W +: DATA_W];
      end
    end
  end

  // Collector state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_OC; k++) begin
        state_q[k] <= S_IDLE;
        need_q[k]  <= '0;
        have_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_OC; k++) begin
        state_q[k] <= state_d[k];
        need_q[k]  <= need_d[k];
        have_q[k]  <= have_d[k];
      end
    end
  end

  // Collector next state; a collector leaving READY on a handshake may be re-allocated in the same cycle
  always_comb begin
    alloc_err = 1'b0;
    for (int unsigned k = 0; k < NUM_OC; k++) begin
      state_d[k] = state_q[k];
      need_d[k]  = need_q[k];
      have_d[k]  = have_q[k] | claim[k];
      unique case (state_q[k])
        S_IDLE: begin
          if (alloc_valid && alloc_oc == 2'(k)) begin
            need_d[k]  = alloc_need;
            have_d[k]  = '0;
            state_d[k] = (alloc_need == 2'b00) ? S_READY : S_GATHER;
          end
        end
        S_GATHER: begin
          if ((have_q[k] & need_q[k]) == need_q[k]) state_d[k] = S_READY;
          if (alloc_valid && alloc_oc == 2'(k)) alloc_err = 1'b1;
        end
        S_READY: begin
          if (hs && disp_oc == 2'(k)) begin
            state_d[k] = S_IDLE;
            if (alloc_valid && alloc_oc == 2'(k)) begin
              need_d[k]  = alloc_need;
              have_d[k]  = '0;
              state_d[k] = (alloc_need == 2'b00) ? S_READY : S_GATHER;
            end
          end else if (alloc_valid && alloc_oc == 2'(k)) begin
            alloc_err = 1'b1;
          end
        end
        default: state_d[k] = S_IDLE;
      endcase
    end
  end

  // Round-robin pick; the collector handshaking now is still READY this cycle so it is excluded
  always_comb begin
    start      = hs ? disp_oc + 2'd1 : rr_ptr;
    pick_valid = 1'b0;
    pick       = '0;
    idx        = '0;
    for (int unsigned i = 0; i < NUM_OC; i++) begin
      idx = start + 2'(i);
      if (!pick_valid && state_q[idx] == S_READY && !(hs && idx == disp_oc)) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

  // Registered dispatch offer, held while the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_valid <= 1'b0;
      disp_oc    <= '0;
      disp_src1  <= '0;
      disp_src2  <= '0;
      rr_ptr     <= '0;
    end else begin
      if (!disp_valid || disp_ready) begin
        disp_valid <= pick_valid;
        disp_oc    <= pick;
        disp_src1  <= (pick_valid && need_q[pick][0]) ? opnd_q[pick][0] : '0;
        disp_src2  <= (pick_valid && need_q[pick][1]) ? opnd_q[pick][1] : '0;
      end
      if (hs) rr_ptr <= disp_oc + 2'd1;
    end
  end

  // Sticky protocol error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= err | ret_err | alloc_err;
  end

  // Busy flags
  always_comb begin
    oc_busy = '0;
    for (int unsigned k = 0; k < 4; k++) oc_busy[k] = (state_q[k] != S_IDLE);
  end

`ifdef OPGATHER_PERF_CNT_EN
  logic [2:0]  ret_cnt;
  logic [16:0] ret_sum;

  // Accepted returns this cycle; a both-slot return counts once
  always_comb begin
    ret_cnt = '0;
    for (int unsigned b = 0; b < 4; b++) ret_cnt = ret_cnt + 3'(wr_mask[b] != 2'b00);
    ret_sum = {1'b0, perf_returns} + 17'(ret_cnt);
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_returns <= '0;
      perf_disps   <= '0;
    end else begin
      perf_returns <= ret_sum[16] ? '1 : ret_sum[15:0];
      if (hs && perf_disps != '1) perf_disps <= perf_disps + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_oc_operand_gather.sv
// Directed bench for oc_operand_gather: table of single-collector transactions plus
// hand sequences for stall/round-robin, conflicts, zero-need alloc and reset (RF_RD_LAT=2).
module tb_oc_operand_gather;
  localparam int DW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance, RF_RD_LAT = 1
  logic          rst;
  logic [3:0]    rf_rd;
  logic [15:0]   ocid;
  logic [3:0]    same;
  logic [4*DW-1:0] rf_data, pend;
  logic          alloc_valid;
  logic [1:0]    alloc_oc, alloc_need;
  logic [3:0]    oc_busy;
  logic          disp_valid, disp_ready;
  logic [1:0]    disp_oc;
  logic [DW-1:0] disp_src1, disp_src2;
  logic          err;

  // second instance, RF_RD_LAT = 2
  logic          b_rst;
  logic [3:0]    b_rf_rd;
  logic [15:0]   b_ocid;
  logic [3:0]    b_same;
  logic [4*DW-1:0] b_rf_data;
  logic          b_alloc_valid;
  logic [1:0]    b_alloc_oc, b_alloc_need;
  logic [3:0]    b_oc_busy;
  logic          b_disp_valid, b_disp_ready;
  logic [1:0]    b_disp_oc;
  logic [DW-1:0] b_disp_src1, b_disp_src2;
  logic          b_err;

  oc_operand_gather #(.DATA_W(DW), .NUM_OC(4), .RF_RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .rf_rd_i(rf_rd), .ocid_i(ocid), .same_i(same),
    .rf_data_i(rf_data), .alloc_valid(alloc_valid), .alloc_oc(alloc_oc),
    .alloc_need(alloc_need), .oc_busy(oc_busy), .disp_valid(disp_valid),
    .disp_ready(disp_ready), .disp_oc(disp_oc), .disp_src1(disp_src1),
    .disp_src2(disp_src2), .err(err)
  );

  oc_operand_gather #(.DATA_W(DW), .NUM_OC(4), .RF_RD_LAT(2)) dut2 (
    .clk(clk), .rst(b_rst), .rf_rd_i(b_rf_rd), .ocid_i(b_ocid), .same_i(b_same),
    .rf_data_i(b_rf_data), .alloc_valid(b_alloc_valid), .alloc_oc(b_alloc_oc),
    .alloc_need(b_alloc_need), .oc_busy(b_oc_busy), .disp_valid(b_disp_valid),
    .disp_ready(b_disp_ready), .disp_oc(b_disp_oc), .disp_src1(b_disp_src1),
    .disp_src2(b_disp_src2), .err(b_err)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  oc;
    logic [1:0]  need;
    int          nret;
    int          b0;
    logic        s0;
    logic        m0;
    logic [31:0] d0;
    int          b1;
    logic        s1;
    logic        m1;
    logic [31:0] d1;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [DW-1:0] pat(input logic [31:0] s);
    return {8{s}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [1:0] oc, input logic [1:0] need);
    alloc_valid = 1'b1;
    alloc_oc    = oc;
    alloc_need  = need;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic set_ret(input int b, input logic [1:0] oc, input logic slot,
                         input logic sm, input logic [31:0] d);
    rf_rd[b]          = 1'b1;
    ocid[4*b +: 4]    = {1'b1, oc, slot};
    same[b]           = sm;
    pend[b*DW +: DW]  = pat(d);
  endtask

  // tag cycle, then data cycle (LAT=1); returns just after the write edge
  task automatic issue();
    tick();
    rf_rd   = '0;
    ocid    = '0;
    same    = '0;
    rf_data = pend;
    pend    = '0;
    tick();
    rf_data = '0;
  endtask

  task automatic handshake();
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{oc:2'd2, need:2'b11, nret:2, b0:1, s0:1'b0, m0:1'b0, d0:32'hAAAA0001,
                b1:3, s1:1'b1, m1:1'b0, d1:32'hBBBB0002, e1:32'hAAAA0001, e2:32'hBBBB0002};
    vecs[1] = '{oc:2'd0, need:2'b11, nret:1, b0:0, s0:1'b0, m0:1'b1, d0:32'hCCCC0003,
                b1:0, s1:1'b0, m1:1'b0, d1:32'h0, e1:32'hCCCC0003, e2:32'hCCCC0003};
    vecs[2] = '{oc:2'd3, need:2'b01, nret:1, b0:2, s0:1'b0, m0:1'b0, d0:32'hEEEE0004,
                b1:0, s1:1'b0, m1:1'b0, d1:32'h0, e1:32'hEEEE0004, e2:32'h0};
    vecs[3] = '{oc:2'd1, need:2'b10, nret:1, b0:0, s0:1'b1, m0:1'b0, d0:32'hFFFF0005,
                b1:0, s1:1'b0, m1:1'b0, d1:32'h0, e1:32'h0, e2:32'hFFFF0005};
    vecs[4] = '{oc:2'd1, need:2'b11, nret:2, b0:3, s0:1'b1, m0:1'b0, d0:32'h12340006,
                b1:2, s1:1'b0, m1:1'b0, d1:32'h56780007, e1:32'h56780007, e2:32'h12340006};
    vecs[5] = '{oc:2'd0, need:2'b10, nret:1, b0:1, s0:1'b0, m0:1'b1, d0:32'h9ABC0008,
                b1:0, s1:1'b0, m1:1'b0, d1:32'h0, e1:32'h0, e2:32'h9ABC0008};

    rst = 1'b0; b_rst = 1'b0;
    rf_rd = '0; ocid = '0; same = '0; rf_data = '0; pend = '0;
    alloc_valid = 1'b0; alloc_oc = '0; alloc_need = '0; disp_ready = 1'b0;
    b_rf_rd = '0; b_ocid = '0; b_same = '0; b_rf_data = '0;
    b_alloc_valid = 1'b0; b_alloc_oc = '0; b_alloc_need = '0; b_disp_ready = 1'b0;
    tick(); tick();
    rst = 1'b1; b_rst = 1'b1;
    tick();

    chk32("rst_valid", 32'(disp_valid), 0);
    chk32("rst_busy", 32'(oc_busy), 0);
    chk32("rst_err", 32'(err), 0);
    chk32("rst_oc", 32'(disp_oc), 0);
    chk("rst_src1", disp_src1, '0);
    chk("rst_src2", disp_src2, '0);
    chk32("rst2_busy", 32'(b_oc_busy), 0);

    // single-collector transactions
    for (int i = 0; i < 6; i++) begin
      do_alloc(vecs[i].oc, vecs[i].need);
      set_ret(vecs[i].b0, vecs[i].oc, vecs[i].s0, vecs[i].m0, vecs[i].d0);
      if (vecs[i].nret > 1) set_ret(vecs[i].b1, vecs[i].oc, vecs[i].s1, vecs[i].m1, vecs[i].d1);
      issue();
      tick();
      chk32($sformatf("row%0d_lat_early", i), 32'(disp_valid), 0);
      tick();
      chk32($sformatf("row%0d_valid", i), 32'(disp_valid), 1);
      chk32($sformatf("row%0d_oc", i), 32'(disp_oc), 32'(vecs[i].oc));
      chk($sformatf("row%0d_src1", i), disp_src1, pat(vecs[i].e1));
      chk($sformatf("row%0d_src2", i), disp_src2, pat(vecs[i].e2));
      chk32($sformatf("row%0d_err", i), 32'(err), 0);
      handshake();
      chk32($sformatf("row%0d_idle", i), 32'(oc_busy), 0);
      chk32($sformatf("row%0d_drop", i), 32'(disp_valid), 0);
    end

    // oc1 and oc3 complete together; consumer stalls
    do_alloc(2'd1, 2'b01);
    do_alloc(2'd3, 2'b01);
    set_ret(0, 2'd1, 1'b0, 1'b0, 32'h11110011);
    set_ret(2, 2'd3, 1'b0, 1'b0, 32'h33330033);
    issue();
    tick(); tick();
    chk32("stall_valid", 32'(disp_valid), 1);
    chk32("stall_oc", 32'(disp_oc), 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk32($sformatf("hold%0d_oc", c), 32'(disp_oc), 1);
      chk($sformatf("hold%0d_src1", c), disp_src1, pat(32'h11110011));
    end
    handshake();
    chk32("next_valid", 32'(disp_valid), 1);
    chk32("next_oc", 32'(disp_oc), 3);
    chk("next_src1", disp_src1, pat(32'h33330033));
    handshake();
    chk32("rr_drained", 32'(disp_valid), 0);

    // pointer is now 0: oc0 must win over oc2
    do_alloc(2'd2, 2'b01);
    do_alloc(2'd0, 2'b01);
    set_ret(1, 2'd2, 1'b0, 1'b0, 32'h22220022);
    set_ret(3, 2'd0, 1'b0, 1'b0, 32'h00000aa0);
    issue();
    tick(); tick();
    chk32("ptr0_oc", 32'(disp_oc), 0);
    chk("ptr0_src1", disp_src1, pat(32'h00000aa0));
    handshake();
    chk32("ptr0_next_oc", 32'(disp_oc), 2);
    chk("ptr0_next_src1", disp_src1, pat(32'h22220022));
    handshake();
    chk32("ptr0_drained", 32'(disp_valid), 0);

    // zero-need alloc, then re-alloc in the handshake cycle
    do_alloc(2'd0, 2'b00);
    chk32("need0_early", 32'(disp_valid), 0);
    chk32("need0_busy", 32'(oc_busy), 1);
    tick();
    chk32("need0_valid", 32'(disp_valid), 1);
    chk32("need0_oc", 32'(disp_oc), 0);
    chk("need0_src1", disp_src1, '0);
    chk("need0_src2", disp_src2, '0);
    disp_ready = 1'b1;
    alloc_valid = 1'b1; alloc_oc = 2'd0; alloc_need = 2'b11;
    tick();
    disp_ready = 1'b0; alloc_valid = 1'b0;
    chk32("realloc_busy", 32'(oc_busy), 1);
    chk32("realloc_valid", 32'(disp_valid), 0);
    chk32("realloc_err", 32'(err), 0);
    set_ret(0, 2'd0, 1'b0, 1'b0, 32'h51515151);
    set_ret(1, 2'd0, 1'b1, 1'b0, 32'h52525252);
    issue();
    tick(); tick();
    chk("realloc_src1", disp_src1, pat(32'h51515151));
    chk("realloc_src2", disp_src2, pat(32'h52525252));
    handshake();

    // two banks to the same oc/slot: lowest bank wins, err set
    do_alloc(2'd1, 2'b01);
    set_ret(0, 2'd1, 1'b0, 1'b0, 32'hD0D0D0D0);
    set_ret(2, 2'd1, 1'b0, 1'b0, 32'hD2D2D2D2);
    issue();
    chk32("conflict_err", 32'(err), 1);
    tick(); tick();
    chk32("conflict_valid", 32'(disp_valid), 1);
    chk("conflict_src1", disp_src1, pat(32'hD0D0D0D0));
    handshake();
    chk32("conflict_idle", 32'(oc_busy), 0);
    chk32("err_sticky", 32'(err), 1);

    // RF_RD_LAT=2: normal transaction
    b_alloc_valid = 1'b1; b_alloc_oc = 2'd2; b_alloc_need = 2'b01;
    tick();
    b_alloc_valid = 1'b0;
    b_rf_rd[3] = 1'b1; b_ocid[15:12] = 4'b1100;
    tick();
    b_rf_rd = '0; b_ocid = '0;
    tick();
    b_rf_data[3*DW +: DW] = pat(32'h7E7E0042);
    tick();
    b_rf_data = '0;
    tick(); tick();
    chk32("lat2_valid", 32'(b_disp_valid), 1);
    chk32("lat2_oc", 32'(b_disp_oc), 2);
    chk("lat2_src1", b_disp_src1, pat(32'h7E7E0042));
    chk32("lat2_err", 32'(b_err), 0);
    b_disp_ready = 1'b1;
    tick();
    b_disp_ready = 1'b0;

    // RF_RD_LAT=2: reset while a tag is in flight
    b_alloc_valid = 1'b1; b_alloc_oc = 2'd0; b_alloc_need = 2'b01;
    tick();
    b_alloc_valid = 1'b0;
    b_rf_rd[0] = 1'b1; b_ocid[3:0] = 4'b1000;
    tick();
    b_rf_rd = '0; b_ocid = '0;
    b_rst = 1'b0;
    #1;
    chk32("mid_rst_busy", 32'(b_oc_busy), 0);
    tick();
    b_rst = 1'b1;
    b_rf_data[0 +: DW] = pat(32'hDEAD0BAD);
    tick();
    b_rf_data = '0;
    chk32("post_rst_err", 32'(b_err), 0);
    chk32("post_rst_busy", 32'(b_oc_busy), 0);
    tick(); tick();
    chk32("post_rst_valid", 32'(b_disp_valid), 0);
    chk32("post_rst_err2", 32'(b_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
